// File: rtl/cu_pkg.sv
// Shared constants and enums for the multicycle control unit.
// Opcode map, ALU control codes, operand selects, FSM states, instruction classes.
package cu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SUBI = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b1000;
    localparam logic [3:0] OP_BR   = 4'b1001;
    localparam logic [3:0] OP_LD   = 4'b1010;
    localparam logic [3:0] OP_ST   = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_MUL,
        CLS_CMP,
        CLS_BR,
        CLS_LD,
        CLS_ST,
        CLS_ILL
    } cls_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode/func decoder: class, ALU control, operand selects, illegal.
// Opcode 0100 decodes as multiply only when CU_MUL_EN is defined.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int F_W  = 2
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [F_W-1:0]  func,
    output cls_t            cls,
    output logic [2:0]      alu_ctrl,
    output logic [1:0]      selop_a,
    output logic [1:0]      selop_b,
    output logic            illegal
);

    logic [3:0] op4;
    logic       bad_op;

    assign op4 = opcode[3:0];

    always_comb begin
        cls      = CLS_NOP;
        alu_ctrl = ALU_ADD;
        selop_a  = SEL_REG;
        selop_b  = SEL_REG;
        bad_op   = 1'b0;
        case (op4)
            OP_ADD:  cls = CLS_ALU;
            OP_SUB: begin
                cls      = CLS_ALU;
                alu_ctrl = ALU_SUB;
            end
            OP_AND: begin
                cls      = CLS_ALU;
                alu_ctrl = ALU_AND;
            end
            OP_OR: begin
                cls      = CLS_ALU;
                alu_ctrl = ALU_OR;
            end
            OP_ADDI: begin
                cls     = CLS_ALU;
                selop_b = SEL_IMM;
            end
            OP_SUBI: begin
                cls      = CLS_ALU;
                alu_ctrl = ALU_SUB;
                selop_b  = SEL_IMM;
            end
            OP_MUL: begin
                alu_ctrl = ALU_MUL;
`ifdef CU_MUL_EN
                cls      = CLS_MUL;
`else
                bad_op   = 1'b1;
`endif
            end
            OP_CMP: begin
                cls      = CLS_CMP;
                alu_ctrl = ALU_SUB;
            end
            OP_BR:   cls = CLS_BR;
            OP_LD: begin
                cls     = CLS_LD;
                selop_b = SEL_IMM;
            end
            OP_ST: begin
                cls     = CLS_ST;
                selop_b = SEL_IMM;
            end
            default: cls = CLS_NOP;
        endcase

        // Reserved upper opcode bits or an all-ones func poison the instruction
        illegal = bad_op || (&func) || ((opcode >> 4) != '0);
        if (illegal) begin
            cls      = CLS_ILL;
            alu_ctrl = ALU_ADD;
            selop_a  = SEL_REG;
            selop_b  = SEL_REG;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB).
// Define CU_MUL_EN to enable the multi-cycle multiply (opcode 0100).
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int F_W     = 2,
    parameter int MUL_LAT = 3,
    parameter int MEM_TO  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [OP_W-1:0] opcode,
    input  logic [F_W-1:0]  func,
    input  logic            cmp_res,
    input  logic            mem_ready,
    output logic [2:0]      alu_ctrl,
    output logic [1:0]      selop_a,
    output logic [1:0]      selop_b,
    output logic            we_reg,
    output logic            we_mem,
    output logic            mem_req,
    output logic            pc_load,
    output logic            pc_inc,
    output logic            busy,
    output logic            illegal,
    output logic            mem_err
);

    if (OP_W < 4) begin : g_bad_opw
        $error("OP_W must be at least 4");
    end
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
        $error("MUL_LAT must be 1..15");
    end
    if (MEM_TO < 1 || MEM_TO > 255) begin : g_bad_to
        $error("MEM_TO must be 1..255");
    end

    localparam logic [7:0] TO_LAST = 8'(MEM_TO - 1);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [F_W-1:0]  func_q, func_d;
    logic            flag_q, flag_d;
    logic [7:0]      tmo_q, tmo_d;
`ifdef CU_MUL_EN
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);
    logic [3:0]      mcnt_q, mcnt_d;
`endif

    cls_t       dec_cls;
    logic [2:0] dec_alu;
    logic [1:0] dec_sela;
    logic [1:0] dec_selb;
    logic       dec_ill;

    cu_decoder #(
        .OP_W (OP_W),
        .F_W  (F_W)
    ) u_dec (
        .opcode   (op_q),
        .func     (func_q),
        .cls      (dec_cls),
        .alu_ctrl (dec_alu),
        .selop_a  (dec_sela),
        .selop_b  (dec_selb),
        .illegal  (dec_ill)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        func_d      = func_q;
        flag_d      = flag_q;
        tmo_d       = tmo_q;
`ifdef CU_MUL_EN
        mcnt_d      = mcnt_q;
`endif
        instr_ready = 1'b0;
        busy        = 1'b1;
        alu_ctrl    = ALU_ADD;
        selop_a     = SEL_REG;
        selop_b     = SEL_REG;
        we_reg      = 1'b0;
        we_mem      = 1'b0;
        mem_req     = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        illegal     = 1'b0;
        mem_err     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy        = 1'b0;
                instr_ready = !rst;
                if (instr_valid) begin
                    op_d    = opcode;
                    func_d  = func;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                selop_a = dec_sela;
                selop_b = dec_selb;
                case (dec_cls)
                    CLS_ILL: begin
                        illegal = dec_ill;
                        state_d = S_IDLE;
                    end
                    CLS_NOP: begin
                        pc_inc  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_EXEC;
`ifdef CU_MUL_EN
                        mcnt_d  = MUL_LAST;
`endif
                    end
                endcase
            end
            S_EXEC: begin
                selop_a  = dec_sela;
                selop_b  = dec_selb;
                alu_ctrl = dec_alu;
                case (dec_cls)
                    CLS_CMP: begin
                        flag_d  = cmp_res;
                        pc_inc  = 1'b1;
                        state_d = S_IDLE;
                    end
                    CLS_BR: begin
                        pc_load = flag_q;
                        pc_inc  = !flag_q;
                        state_d = S_IDLE;
                    end
                    CLS_LD, CLS_ST: begin
                        tmo_d   = '0;
                        state_d = S_MEM;
                    end
`ifdef CU_MUL_EN
                    CLS_MUL: begin
                        if (mcnt_q != '0) begin
                            mcnt_d = mcnt_q - 4'd1;
                        end else begin
                            state_d = S_WB;
                        end
                    end
`endif
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                selop_a = dec_sela;
                selop_b = dec_selb;
                mem_req = 1'b1;
                // A completion on the last allowed cycle beats the timeout
                if (mem_ready) begin
                    if (dec_cls == CLS_ST) begin
                        we_mem  = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_q == TO_LAST) begin
                    mem_err = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WB: begin
                we_reg  = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            func_q  <= '0;
            flag_q  <= 1'b0;
            tmo_q   <= '0;
`ifdef CU_MUL_EN
            mcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            func_q  <= func_d;
            flag_q  <= flag_d;
            tmo_q   <= tmo_d;
`ifdef CU_MUL_EN
            mcnt_q  <= mcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; expected control words hand-written.
// Build with +define+CU_MUL_EN to exercise the multiply path instead of its illegal trap.
module tb_multicycle_control_unit;

    localparam int OP_W    = 4;
    localparam int F_W     = 2;
    localparam int MUL_LAT = 3;
    localparam int MEM_TO  = 15;

    logic            clk         = 1'b0;
    logic            rst         = 1'b1;
    logic            instr_valid = 1'b0;
    logic [OP_W-1:0] opcode      = '0;
    logic [F_W-1:0]  func        = '0;
    logic            cmp_res     = 1'b0;
    logic            mem_ready   = 1'b0;
    logic            instr_ready;
    logic [2:0]      alu_ctrl;
    logic [1:0]      selop_a;
    logic [1:0]      selop_b;
    logic            we_reg;
    logic            we_mem;
    logic            mem_req;
    logic            pc_load;
    logic            pc_inc;
    logic            busy;
    logic            illegal;
    logic            mem_err;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OP_W    (OP_W),
        .F_W     (F_W),
        .MUL_LAT (MUL_LAT),
        .MEM_TO  (MEM_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .func        (func),
        .cmp_res     (cmp_res),
        .mem_ready   (mem_ready),
        .alu_ctrl    (alu_ctrl),
        .selop_a     (selop_a),
        .selop_b     (selop_b),
        .we_reg      (we_reg),
        .we_mem      (we_mem),
        .mem_req     (mem_req),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .busy        (busy),
        .illegal     (illegal),
        .mem_err     (mem_err)
    );

    logic [8:0] fl;
    assign fl = {instr_ready, busy, we_reg, we_mem, mem_req,
                 pc_load, pc_inc, illegal, mem_err};

    localparam logic [8:0] R  = 9'h100;
    localparam logic [8:0] B  = 9'h080;
    localparam logic [8:0] WR = 9'h040;
    localparam logic [8:0] WM = 9'h020;
    localparam logic [8:0] MQ = 9'h010;
    localparam logic [8:0] PL = 9'h008;
    localparam logic [8:0] PI = 9'h004;
    localparam logic [8:0] IL = 9'h002;
    localparam logic [8:0] ME = 9'h001;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Called settled in IDLE; returns settled in DECODE.
    task automatic issue(input logic [3:0] op, input logic [1:0] fn, input string tag);
        opcode      = op;
        func        = fn;
        instr_valid = 1'b1;
        #1;
        chk({tag, ".xfer"}, fl, R);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        opcode      = '0;
        func        = '0;
        #2;
    endtask

    task automatic run_alu(input logic [3:0] op, input logic [2:0] alu,
                           input logic [1:0] sb, input string tag);
        issue(op, 2'b00, tag);
        chk({tag, ".dec"}, fl, B);
        step();
        chk({tag, ".exec"}, fl, B);
        chk({tag, ".alu"}, {6'b0, alu_ctrl}, {6'b0, alu});
        chk({tag, ".sela"}, {7'b0, selop_a}, 9'h000);
        chk({tag, ".selb"}, {7'b0, selop_b}, {7'b0, sb});
        step();
        chk({tag, ".wb"}, fl, B | WR | PI);
        step();
        chk({tag, ".idle"}, fl, R);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #2;
        chk("rst.hold", fl, 9'h000);
        chk("rst.alu", {6'b0, alu_ctrl}, 9'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst.rel", fl, R);
        step();
        chk("idle", fl, R);

        run_alu(4'b0000, 3'b000, 2'b00, "add");
        run_alu(4'b0010, 3'b001, 2'b00, "sub");
        run_alu(4'b0101, 3'b011, 2'b00, "and");
        run_alu(4'b0110, 3'b100, 2'b00, "or");
        run_alu(4'b0001, 3'b000, 2'b01, "addi");
        run_alu(4'b0011, 3'b001, 2'b01, "subi");

        issue(4'b0111, 2'b00, "nop");
        chk("nop.dec", fl, B | PI);
        step();
        chk("nop.idle", fl, R);

        issue(4'b0000, 2'b11, "ilf");
        chk("ilf.dec", fl, B | IL);
        step();
        chk("ilf.idle", fl, R);

        issue(4'b0100, 2'b00, "mul");
`ifdef CU_MUL_EN
        chk("mul.dec", fl, B);
        for (int i = 0; i < MUL_LAT; i++) begin
            step();
            chk("mul.exec", fl, B);
            chk("mul.alu", {6'b0, alu_ctrl}, 9'h002);
        end
        step();
        chk("mul.wb", fl, B | WR | PI);
        step();
        chk("mul.idle", fl, R);
`else
        chk("mul.ill", fl, B | IL);
        step();
        chk("mul.idle", fl, R);
`endif

        issue(4'b1000, 2'b00, "cmp1");
        chk("cmp1.dec", fl, B);
        @(posedge clk);
        #1;
        cmp_res = 1'b1;
        #2;
        chk("cmp1.exec", fl, B | PI);
        chk("cmp1.alu", {6'b0, alu_ctrl}, 9'h001);
        @(posedge clk);
        #1;
        cmp_res = 1'b0;
        #2;
        chk("cmp1.idle", fl, R);

        issue(4'b1001, 2'b00, "brt");
        chk("brt.dec", fl, B);
        step();
        chk("brt.exec", fl, B | PL);
        step();
        chk("brt.idle", fl, R);

        issue(4'b1001, 2'b00, "brt2");
        step();
        chk("brt2.exec", fl, B | PL);
        step();

        issue(4'b1000, 2'b00, "cmp0");
        step();
        chk("cmp0.exec", fl, B | PI);
        step();
        chk("cmp0.idle", fl, R);

        issue(4'b1001, 2'b00, "brn");
        step();
        chk("brn.exec", fl, B | PI);
        step();
        chk("brn.idle", fl, R);

        issue(4'b1111, 2'b00, "st");
        chk("st.dec", fl, B);
        step();
        chk("st.exec", fl, B);
        chk("st.alu", {6'b0, alu_ctrl}, 9'h000);
        chk("st.selb", {7'b0, selop_b}, 9'h001);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("st.mem", fl, B | MQ);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #2;
        chk("st.done", fl, B | MQ | WM | PI);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #2;
        chk("st.idle", fl, R);

        issue(4'b1111, 2'b00, "sto");
        step();
        for (int i = 1; i < MEM_TO; i++) begin
            step();
            chk("sto.mem", fl, B | MQ);
        end
        step();
        chk("sto.err", fl & ~PI, B | MQ | ME);
        step();
        chk("sto.idle", fl, R);

        issue(4'b1010, 2'b00, "ldl");
        step();
        chk("ldl.selb", {7'b0, selop_b}, 9'h001);
        for (int i = 1; i < MEM_TO; i++) begin
            step();
            chk("ldl.mem", fl, B | MQ);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #2;
        chk("ldl.last", fl, B | MQ);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #2;
        chk("ldl.wb", fl, B | WR | PI);
        step();
        chk("ldl.idle", fl, R);

        issue(4'b1000, 2'b00, "cmp2");
        @(posedge clk);
        #1;
        cmp_res = 1'b1;
        #2;
        @(posedge clk);
        #1;
        cmp_res = 1'b0;
        #2;

        issue(4'b1010, 2'b00, "ldr");
        step();
        step();
        chk("ldr.mem", fl, B | MQ);
        #1;
        rst = 1'b1;
        #1;
        chk("ldr.rst", fl, 9'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("ldr.rel", fl, R);
        step();
        chk("ldr.nowb", fl, R);

        issue(4'b1001, 2'b00, "brr");
        step();
        chk("brr.exec", fl, B | PI);
        step();
        chk("brr.idle", fl, R);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OP_W, default 4, opcode width (min 4).
REQ-002 Parameter F_W, default 2, function-field width.
REQ-003 Parameter MUL_LAT, default 3, multiply execute cycles (1..15).
REQ-004 Parameter MEM_TO, default 15, memory-wait timeout in cycles (1..255).
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 instr_valid  in  1  instruction offered; instr_ready  out  1  accept, transfer when both high.
REQ-008 opcode  in  OP_W  and  func  in  F_W: instruction fields, sampled on transfer.
REQ-009 cmp_res  in  1  ALU compare result, sampled at end of compare EXEC.
REQ-010 mem_ready  in  1  memory completion strobe.
REQ-011 alu_ctrl  out  3  (000 add, 001 sub, 010 mul, 011 and, 100 or); selop_a, selop_b  out  2 each  operand selects.
REQ-012 we_reg, we_mem, mem_req, pc_load, pc_inc, busy, illegal, mem_err  out  1 each, all active-high.

Function
REQ-013 States: IDLE, DECODE, EXEC, MEM, WB; instr_ready high only in IDLE; busy high in every other state.
REQ-014 Transfer: IDLE->DECODE, opcode/func latched; inputs ignored while busy.
REQ-015 Classes: 0000/0010/0101/0110 ALU-reg, 0001/0011 ALU-imm, 0100 MUL, 1000 CMP, 1001 BR, 1010 LD, 1111 ST; other opcodes are NOP.
REQ-016 func all-ones, or undefined opcode bits above bit 3 nonzero: illegal pulses 1 cycle in DECODE, no write/branch, DECODE->IDLE.
REQ-017 DECODE->EXEC for ALU, MUL, CMP, BR, LD, ST; NOP goes DECODE->IDLE with pc_inc pulse.
REQ-018 ALU ops: EXEC 1 cycle, then WB; we_reg 1-cycle pulse in WB; total 4 cycles from transfer to instr_ready.
REQ-019 MUL: EXEC held exactly MUL_LAT cycles by down-counter, alu_ctrl=010 throughout, then WB.
REQ-020 CMP: 1-cycle EXEC, alu_ctrl=001, internal flag <= cmp_res at EXEC end; no we_reg; EXEC->IDLE.
REQ-021 BR: 1-cycle EXEC; flag=1 -> pc_load pulse, else pc_inc; flag unchanged; EXEC->IDLE.
REQ-022 LD/ST: EXEC (address add, alu_ctrl=000) -> MEM; mem_req held high in MEM until mem_ready.
REQ-023 ST: we_mem high in MEM cycle where mem_ready=1, then IDLE; LD: MEM->WB, we_reg pulse.
REQ-024 MEM timeout: MEM_TO cycles without mem_ready -> mem_err 1-cycle pulse, no write, ->IDLE; mem_ready on final cycle wins over timeout.
REQ-025 pc_inc pulses 1 cycle on final cycle of every non-branch-taken, non-illegal instruction.
REQ-026 selop_a/selop_b: imm and LD/ST select 01 on B; otherwise 00; stable through EXEC.

Reset
REQ-027 rst asserted: immediate IDLE, flag=0, counters=0, every output 0 except instr_ready=1 after release.
REQ-028 rst mid-MEM drops mem_req same cycle; pending write never issued.

Configuration
REQ-029 Macro CU_MUL_EN defined: MUL as REQ-019.
REQ-030 CU_MUL_EN undefined: opcode 0100 treated as illegal per REQ-016; no multiply counter synthesised.

Structure
REQ-031 Package cu_pkg holds opcode constants, alu_ctrl codes, state enum, instruction-class enum.
REQ-032 One sub-module cu_decoder: combinational opcode/func -> class, alu_ctrl, selops, illegal.

Verification
REQ-033 Reset then opcode 0000 func 00: we_reg pulse exactly cycle 4 after transfer, alu_ctrl=000 in EXEC, pc_inc in WB.
REQ-034 MUL_LAT=3, opcode 0100: busy 5 cycles, EXEC 3 cycles; with CU_MUL_EN undefined, illegal=1 in DECODE.
REQ-035 CMP with cmp_res=1, then BR: pc_load=1, pc_inc=0; CMP cmp_res=0 then BR: pc_inc=1.
REQ-036 ST, mem_ready after 4 MEM cycles: mem_req high 4 cycles, we_mem pulse in cycle 4; no mem_ready for 15 cycles: mem_err, no we_mem.
REQ-037 rst asserted during LD MEM: mem_req 0 immediately, no we_reg, instr_ready=1 after release.
